// File: rtl/user_pulse_meter_pkg.sv
// Shared user-domain definitions for the pulse meter: FSM state encoding and helpers.
package user_pulse_meter_pkg;

  localparam int unsigned MeterStateWidth = 3;

  typedef enum logic [MeterStateWidth-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EDGE = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_DONE      = 3'd3,
    ST_TIMEOUT   = 3'd4
  } meter_state_e;

  // Terminal states raise the one-cycle completion strobe on entry.
  function automatic logic is_final_state(input meter_state_e s);
    return (s == ST_DONE) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/user_pulse_meter_sync.sv
// Multi-flop synchronizer bringing the asynchronous pulse input into the clk_i domain.
module user_pulse_meter_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/user_pulse_meter.sv
// Measures active-time and period of an external pulse train, counts complete periods,
// and stops on a programmed count, on an edge timeout, or on abort.
module user_pulse_meter
  import user_pulse_meter_pkg::*;
#(
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned NumWidth   = 8,
  parameter int unsigned SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pulse_i,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic                invert_in_i,
  input  logic [NumWidth-1:0] num_pulses_i,
  input  logic [CntWidth-1:0] timeout_i,
  output logic [CntWidth-1:0] high_o,
  output logic [CntWidth-1:0] period_o,
  output logic [NumWidth-1:0] pulse_cnt_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic                sat_o,
  output logic [2:0]          state_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [NumWidth-1:0] NumMax = '1;

  meter_state_e state_q, state_d;

  logic pulse_sync;
  logic act, act_q;
  logic rise, fall, any_edge;

  logic [CntWidth-1:0] per_q, per_d;
  logic [CntWidth-1:0] hi_q, hi_d;
  logic [CntWidth-1:0] idle_q, idle_d;
  logic [CntWidth-1:0] high_q, high_d;
  logic [CntWidth-1:0] period_q, period_d;
  logic [NumWidth-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                tout_q, tout_d;
  logic                sat_q, sat_d;

  logic [CntWidth-1:0] idle_inc;
  logic [NumWidth-1:0] cnt_inc;
  logic                timeout_hit;
  logic                count_reached;

  user_pulse_meter_sync #(
    .Stages(SyncStages)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (pulse_i),
    .q_o   (pulse_sync)
  );

  // Edge detect on the synchronized active level; a level already present at arm is no edge.
  assign act = pulse_sync ^ invert_in_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q <= 1'b0;
    end else begin
      act_q <= act;
    end
  end

  assign rise     = act & ~act_q;
  assign fall     = ~act & act_q;
  assign any_edge = rise | fall;

  // idle_inc is the edge-free run length including the current cycle.
  assign idle_inc      = idle_q + CntWidth'(1);
  assign cnt_inc       = cnt_q + NumWidth'(1);
  assign timeout_hit   = (timeout_i != '0) && !any_edge && (idle_inc == timeout_i);
  assign count_reached = (cnt_inc == num_pulses_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other request.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            state_d = (num_pulses_i == '0) ? ST_DONE : ST_WAIT_EDGE;
          end
        end
        ST_WAIT_EDGE: begin
          if (rise) begin
            state_d = ST_MEASURE;
          end else if (timeout_hit) begin
            state_d = ST_TIMEOUT;
          end
        end
        ST_MEASURE: begin
          if (rise && count_reached) begin
            state_d = ST_DONE;
          end else if (timeout_hit) begin
            state_d = ST_TIMEOUT;
          end
        end
        ST_DONE:    state_d = ST_IDLE;
        ST_TIMEOUT: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values; everything holds unless a rule below fires.
  always_comb begin
    per_d    = per_q;
    hi_d     = hi_q;
    idle_d   = idle_q;
    high_d   = high_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    tout_d   = tout_q;
    done_d   = is_final_state(state_d);

    if (!abort_i) begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            per_d    = '0;
            hi_d     = '0;
            idle_d   = '0;
            high_d   = '0;
            period_d = '0;
            cnt_d    = '0;
            sat_d    = 1'b0;
            tout_d   = 1'b0;
          end
        end
        ST_WAIT_EDGE, ST_MEASURE: begin
          if (any_edge) begin
            idle_d = '0;
          end else if (idle_q != CntMax) begin
            idle_d = idle_inc;
          end

          if (rise) begin
            if (state_q == ST_MEASURE) begin
              period_d = per_q;
              high_d   = hi_q;
              if (cnt_q != NumMax) begin
                cnt_d = cnt_inc;
              end
            end
            per_d = CntWidth'(1);
            hi_d  = CntWidth'(1);
          end else if (state_q == ST_MEASURE) begin
            if (per_q == CntMax) begin
              sat_d = 1'b1;
            end else begin
              per_d = per_q + CntWidth'(1);
            end
            // Active level only persists until the fall, so hi_cnt freezes from then on.
            if (act) begin
              if (hi_q == CntMax) begin
                sat_d = 1'b1;
              end else begin
                hi_d = hi_q + CntWidth'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end

    if (state_d == ST_TIMEOUT) begin
      tout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      per_q    <= '0;
      hi_q     <= '0;
      idle_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      per_q    <= per_d;
      hi_q     <= hi_d;
      idle_q   <= idle_d;
      high_q   <= high_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
      sat_q    <= sat_d;
    end
  end

  assign high_o      = high_q;
  assign period_o    = period_q;
  assign pulse_cnt_o = cnt_q;
  assign done_o      = done_q;
  assign timeout_o   = tout_q;
  assign sat_o       = sat_q;
  assign state_o     = 3'(state_q);

endmodule

// File: tb/tb_user_pulse_meter.sv
// Scoreboard bench for user_pulse_meter: random pulse trains against an arithmetic period model.
module tb_user_pulse_meter;

  typedef struct packed {
    logic [15:0] high;
    logic [15:0] period;
    logic [7:0]  cnt;
    logic        tout;
    logic        sat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pulse;
  logic        arm;
  logic        abort;
  logic        invert;
  logic [7:0]  num;
  logic [15:0] timeout;
  logic [3:0]  timeout4;

  logic [15:0] high_o, period_o;
  logic [7:0]  pulse_cnt_o;
  logic        done_o, timeout_o, sat_o;
  logic [2:0]  state_o;

  logic [3:0]  high4, period4;
  logic [7:0]  cnt4;
  logic        done4, tout4, sat4;
  logic [2:0]  state4;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  bit   inv_cur  = 1'b0;
  int   h_arr[1:8];
  int   l_arr[1:8];

  user_pulse_meter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pulse_i     (pulse),
    .arm_i       (arm),
    .abort_i     (abort),
    .invert_in_i (invert),
    .num_pulses_i(num),
    .timeout_i   (timeout),
    .high_o      (high_o),
    .period_o    (period_o),
    .pulse_cnt_o (pulse_cnt_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .sat_o       (sat_o),
    .state_o     (state_o)
  );

  user_pulse_meter #(.CntWidth(4), .NumWidth(8), .SyncStages(2)) dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pulse_i     (pulse),
    .arm_i       (arm),
    .abort_i     (abort),
    .invert_in_i (invert),
    .num_pulses_i(num),
    .timeout_i   (timeout4),
    .high_o      (high4),
    .period_o    (period4),
    .pulse_cnt_o (cnt4),
    .done_o      (done4),
    .timeout_o   (tout4),
    .sat_o       (sat4),
    .state_o     (state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
  endtask

  // Monitor: every completion strobe is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("res_high",    64'(high_o),      64'(mon_e.high));
        check("res_period",  64'(period_o),    64'(mon_e.period));
        check("res_cnt",     64'(pulse_cnt_o), 64'(mon_e.cnt));
        check("res_timeout", 64'(timeout_o),   64'(mon_e.tout));
        check("res_sat",     64'(sat_o),       64'(mon_e.sat));
      end
    end
  end

  // Holds the active (1) or inactive (0) level for len cycles, in active-level terms.
  task automatic drive_seg(input bit active, input int len);
    pulse = active ^ inv_cur;
    repeat (len) begin
      @(negedge clk);
      arm = 1'b0;
    end
  endtask

  task automatic settle(input int n, input bit inv, input int tmo);
    @(negedge clk);
    inv_cur = inv;
    invert  = inv;
    pulse   = inv;
    num     = 8'(n);
    timeout = 16'(tmo);
    repeat (6) @(negedge clk);
  endtask

  // stop_m == 0: full run of n periods; otherwise the input goes quiet after the stop_m-th rise.
  task automatic run_meas(input int n, input bit inv, input int tmo, input int stop_m,
                          input bit mid_arm);
    exp_t e;
    int   d0;
    settle(n, inv, tmo);
    e = '0;
    if (stop_m == 0) begin
      e.cnt = 8'(n);
      if (n > 0) begin
        e.high   = 16'(h_arr[n]);
        e.period = 16'(h_arr[n] + l_arr[n]);
      end
    end else begin
      e.cnt  = 8'(stop_m - 1);
      e.tout = 1'b1;
      if (stop_m >= 2) begin
        e.high   = 16'(h_arr[stop_m-1]);
        e.period = 16'(h_arr[stop_m-1] + l_arr[stop_m-1]);
      end
    end
    sb_q.push_back(e);
    d0 = done_cnt;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    if (stop_m == 0) begin
      for (int i = 1; i <= n; i++) begin
        if (i == 2 && mid_arm) arm = 1'b1;
        drive_seg(1'b1, h_arr[i]);
        drive_seg(1'b0, l_arr[i]);
      end
      if (n > 0) begin
        drive_seg(1'b1, 3);
        drive_seg(1'b0, 4);
      end
    end else begin
      for (int i = 1; i < stop_m; i++) begin
        drive_seg(1'b1, h_arr[i]);
        drive_seg(1'b0, l_arr[i]);
      end
      drive_seg(1'b1, h_arr[stop_m]);
      pulse = inv_cur;
    end
    for (int c = 0; c < 400 && sb_q.size() != 0; c++) @(negedge clk);
    check("done_seen", 64'(sb_q.size()), 64'(0));
    sb_q.delete();
    repeat (2) @(negedge clk);
    check("state_idle", 64'(state_o), 64'(0));
    check("done_count", 64'(done_cnt - d0), 64'(1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    int n;
    int tmo;
    int stop_m;
    bit inv;
    exp_t e;

    rst_n = 1'b0; pulse = 1'b0; arm = 1'b0; abort = 1'b0; invert = 1'b0;
    num = 8'd0; timeout = 16'd0; timeout4 = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({high_o, period_o, pulse_cnt_o, done_o, timeout_o, sat_o, state_o}), 64'(0));
    rst_n = 1'b1;

    // Loopback-style train: active 3 of 10 clocks, four periods.
    for (int i = 1; i <= 8; i++) begin h_arr[i] = 3; l_arr[i] = 7; end
    run_meas(4, 1'b0, 0, 0, 1'b0);

    // Inverted input: low 7 / high 5 -> active 7 of 12.
    for (int i = 1; i <= 8; i++) begin h_arr[i] = 7; l_arr[i] = 5; end
    run_meas(2, 1'b1, 0, 0, 1'b0);

    // Static input after arm: timeout exactly 20 clocks after the arm edge.
    settle(5, 1'b0, 20);
    e = '0; e.tout = 1'b1;
    sb_q.push_back(e);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    k = 1;
    while (!done_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", 64'(k), 64'(21));
    repeat (3) @(negedge clk);
    check("timeout_sticky", 64'(timeout_o), 64'(1));
    check("timeout_idle", 64'(state_o), 64'(0));
    check("timeout_sb_empty", 64'(sb_q.size()), 64'(0));
    sb_q.delete();

    // Random trains: complete runs, early-quiet runs that time out, ignored mid-run arms.
    for (int r = 0; r < 24; r++) begin
      n   = $urandom_range(1, 6);
      inv = 1'($urandom_range(0, 1));
      tmo = ($urandom_range(0, 1) == 1) ? 60 : 0;
      stop_m = (tmo != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      for (int i = 1; i <= 8; i++) begin
        h_arr[i] = $urandom_range(1, 12);
        l_arr[i] = $urandom_range(1, 12);
      end
      run_meas(n, inv, tmo, stop_m, 1'($urandom_range(0, 1)));
    end

    // Abort after two complete periods: results hold, no completion strobe.
    settle(5, 1'b0, 0);
    d0 = done_cnt;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    drive_seg(1'b1, 4); drive_seg(1'b0, 6);
    drive_seg(1'b1, 4); drive_seg(1'b0, 6);
    drive_seg(1'b1, 4);
    abort = 1'b1;
    arm   = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    arm   = 1'b0;
    check("abort_state", 64'(state_o), 64'(0));
    check("abort_cnt", 64'(pulse_cnt_o), 64'(2));
    check("abort_period", 64'(period_o), 64'(10));
    check("abort_high", 64'(high_o), 64'(4));
    pulse = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'(0));
    check("abort_stays_idle", 64'(state_o), 64'(0));

    // Zero target: strobe on the cycle after arm, results cleared, single-cycle strobe.
    settle(0, 1'b0, 0);
    sb_q.push_back(exp_t'(0));
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("zero_done", 64'(done_o), 64'(1));
    @(negedge clk);
    check("zero_strobe_one_cycle", 64'(done_o), 64'(0));
    check("zero_sb_empty", 64'(sb_q.size()), 64'(0));
    sb_q.delete();

    // Saturation on the 4-bit instance with a 20-clock period (5 active).
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    h_arr[1] = 5; l_arr[1] = 15;
    run_meas(1, 1'b0, 0, 0, 1'b0);
    check("sat4_period", 64'(period4), 64'(15));
    check("sat4_high", 64'(high4), 64'(5));
    check("sat4_flag", 64'(sat4), 64'(1));
    check("sat4_cnt", 64'(cnt4), 64'(1));
    check("sat16_flag", 64'(sat_o), 64'(0));

    // Asynchronous reset in the middle of a measurement.
    settle(3, 1'b0, 0);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    drive_seg(1'b1, 4); drive_seg(1'b0, 6);
    drive_seg(1'b1, 4); drive_seg(1'b0, 3);
    check("pre_reset_cnt", 64'(pulse_cnt_o), 64'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_main",
          64'({high_o, period_o, pulse_cnt_o, done_o, timeout_o, sat_o, state_o}), 64'(0));
    check("async_reset_sat4",
          64'({high4, period4, cnt4, done4, tout4, sat4, state4}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 64'(state_o), 64'(0));
    check("final_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
